pll_dyn_cfg_ctrl: RTL and testbench

- Upstream controller for the Ethernet clock PLL that exposes dynamic charge-pump and loop-filter inputs plus reset, and returns an asynchronous lock.
- Drives the PLL's reset and icpsel/lpfres/lpfcap from a parameterised table of candidate settings.
- Qualifies lock over a stable window and steps to the next table entry on lock timeout.
- Re-locks on lock loss, and reports ready/fail status to the Ethernet reset logic.

---
 rtl/pll_cfg_pkg.sv | 29 ++
 rtl/pll_lock_sync.sv | 29 ++
 rtl/pll_dyn_cfg_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pll_dyn_cfg_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared types and helpers for the Ethernet PLL dynamic-configuration controller:
// FSM state encodings, table entry layout and an entry extraction function.
package pll_cfg_pkg;

    localparam int CFG_W         = 11;
    localparam int CFG_MAX       = 16;
    localparam int CFG_TBL_MAX_W = CFG_W * CFG_MAX;

    localparam int ICP_LSB = 5;
    localparam int ICP_W   = 6;
    localparam int RES_LSB = 2;
    localparam int RES_W   = 3;
    localparam int CAP_LSB = 0;
    localparam int CAP_W   = 2;

    typedef logic [1:0] pll_state_t;

    localparam pll_state_t ST_HOLD   = 2'd0;
    localparam pll_state_t ST_WAIT   = 2'd1;
    localparam pll_state_t ST_LOCKED = 2'd2;
    localparam pll_state_t ST_FAIL   = 2'd3;

    // Entry idx lives at [CFG_W*idx +: CFG_W]; the table is zero-extended to the maximum size.
    function automatic logic [CFG_W-1:0] cfg_entry(input logic [CFG_TBL_MAX_W-1:0] tbl,
                                                   input int idx);
        return tbl[CFG_W*idx +: CFG_W];
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clk domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// Sequences the Ethernet PLL through a table of loop settings until it holds
// lock for a stable window, re-locking on loss and flagging failure when all entries time out.
module pll_dyn_cfg_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int NUM_CFG = 4,
    parameter logic [NUM_CFG*11-1:0] CFG_TABLE = {6'd12, 3'd4, 2'd0,
                                                  6'd24, 3'd1, 2'd1,
                                                  6'd16, 3'd3, 2'd0,
                                                  6'd20, 3'd2, 2'd0},
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 1024,
    localparam int IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_req,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [5:0]       icpsel,
    output logic [2:0]       lpfres,
    output logic [1:0]       lpfcap,
    output logic             pll_ready,
    output logic             cfg_fail,
    output logic [IDX_W-1:0] cfg_idx,
    output logic [7:0]       lost_cnt
);

    localparam int RC_W = $clog2(RST_CYCLES);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int ST_W = $clog2(LOCK_STABLE + 1);

    localparam logic [CFG_TBL_MAX_W-1:0] TABLE_EXT = CFG_TBL_MAX_W'(CFG_TABLE);
    localparam logic [CFG_W-1:0]         ENTRY0    = cfg_entry(TABLE_EXT, 0);
    localparam logic [RC_W-1:0]          RST_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]          TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]          TO_MAX    = TO_W'(LOCK_TIMEOUT);
    localparam logic [ST_W-1:0]          STAB_LAST = ST_W'(LOCK_STABLE - 1);
    localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(NUM_CFG - 1);

    logic lock_s;

    pll_state_t       state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [ST_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic [IDX_W-1:0] cfg_idx_q, cfg_idx_d;
    logic [CFG_W-1:0] cfg_sel_q, cfg_sel_d;
    logic             pll_reset_q, pll_reset_d;
    logic             pll_ready_q, pll_ready_d;
    logic             cfg_fail_q, cfg_fail_d;
    logic [7:0]       lost_cnt_q, lost_cnt_d;

    pll_lock_sync u_lock_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pll_lock),
        .sync_out (lock_s)
    );

    // cfg_sel only ever changes on transitions that also force pll_reset high.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        to_cnt_d    = to_cnt_q;
        stab_cnt_d  = stab_cnt_q;
        cfg_idx_d   = cfg_idx_q;
        cfg_sel_d   = cfg_sel_q;
        pll_reset_d = pll_reset_q;
        pll_ready_d = pll_ready_q;
        cfg_fail_d  = cfg_fail_q;
        lost_cnt_d  = lost_cnt_q;

        if (cfg_req) begin
            state_d     = ST_HOLD;
            rst_cnt_d   = '0;
            to_cnt_d    = '0;
            stab_cnt_d  = '0;
            cfg_idx_d   = '0;
            cfg_sel_d   = ENTRY0;
            pll_reset_d = 1'b1;
            pll_ready_d = 1'b0;
            cfg_fail_d  = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    pll_reset_d = 1'b1;
                    pll_ready_d = 1'b0;
                    if (rst_cnt_q == RST_LAST) begin
                        rst_cnt_d   = '0;
                        to_cnt_d    = '0;
                        stab_cnt_d  = '0;
                        pll_reset_d = 1'b0;
                        state_d     = ST_WAIT;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RC_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (to_cnt_q != TO_MAX) begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                    stab_cnt_d = lock_s ? stab_cnt_q + ST_W'(1) : '0;
                    // Stable completion takes precedence over a coincident timeout.
                    if (lock_s && (stab_cnt_q == STAB_LAST)) begin
                        state_d     = ST_LOCKED;
                        pll_ready_d = 1'b1;
                    end else if (to_cnt_q == TO_LAST) begin
                        pll_reset_d = 1'b1;
                        stab_cnt_d  = '0;
                        rst_cnt_d   = '0;
                        if (cfg_idx_q == IDX_LAST) begin
                            state_d    = ST_FAIL;
                            cfg_fail_d = 1'b1;
                        end else begin
                            cfg_idx_d = cfg_idx_q + IDX_W'(1);
                            cfg_sel_d = cfg_entry(TABLE_EXT, int'(cfg_idx_q) + 1);
                            state_d   = ST_HOLD;
                        end
                    end
                end
                ST_LOCKED: begin
                    pll_ready_d = 1'b1;
                    if (!lock_s) begin
                        pll_ready_d = 1'b0;
                        pll_reset_d = 1'b1;
                        rst_cnt_d   = '0;
                        stab_cnt_d  = '0;
                        state_d     = ST_HOLD;
                        if (lost_cnt_q != 8'hFF) begin
                            lost_cnt_d = lost_cnt_q + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    pll_reset_d = 1'b1;
                    pll_ready_d = 1'b0;
                end
                default: begin
                    state_d     = ST_HOLD;
                    rst_cnt_d   = '0;
                    pll_reset_d = 1'b1;
                    pll_ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            stab_cnt_q  <= '0;
            cfg_idx_q   <= '0;
            cfg_sel_q   <= ENTRY0;
            pll_reset_q <= 1'b1;
            pll_ready_q <= 1'b0;
            cfg_fail_q  <= 1'b0;
            lost_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            stab_cnt_q  <= stab_cnt_d;
            cfg_idx_q   <= cfg_idx_d;
            cfg_sel_q   <= cfg_sel_d;
            pll_reset_q <= pll_reset_d;
            pll_ready_q <= pll_ready_d;
            cfg_fail_q  <= cfg_fail_d;
            lost_cnt_q  <= lost_cnt_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign icpsel    = cfg_sel_q[ICP_LSB +: ICP_W];
    assign lpfres    = cfg_sel_q[RES_LSB +: RES_W];
    assign lpfcap    = cfg_sel_q[CAP_LSB +: CAP_W];
    assign pll_ready = pll_ready_q;
    assign cfg_fail  = cfg_fail_q;
    assign cfg_idx   = cfg_idx_q;
    assign lost_cnt  = lost_cnt_q;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Directed bench for pll_dyn_cfg_ctrl: a table of timed checkpoints through lock,
// loss, glitch, timeout stepping, fail and restart, then a lost_cnt saturation run.
module tb_pll_dyn_cfg_ctrl;

    localparam logic [10:0] E0 = {6'd20, 3'd2, 2'd0};
    localparam logic [10:0] E1 = {6'd16, 3'd3, 2'd0};
    localparam logic [10:0] E2 = {6'd24, 3'd1, 2'd1};
    localparam logic [10:0] E3 = {6'd12, 3'd4, 2'd0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_req;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap;
    logic       pll_ready;
    logic       cfg_fail;
    logic [1:0] cfg_idx;
    logic [7:0] lost_cnt;

    int checks = 0;
    int errors = 0;

    pll_dyn_cfg_ctrl #(
        .NUM_CFG      (4),
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .LOCK_STABLE  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_req   (cfg_req),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .icpsel    (icpsel),
        .lpfres    (lpfres),
        .lpfcap    (lpfcap),
        .pll_ready (pll_ready),
        .cfg_fail  (cfg_fail),
        .cfg_idx   (cfg_idx),
        .lost_cnt  (lost_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        lock;
        logic        req;
        logic        rst;
        logic        rdy;
        logic        fail;
        logic [1:0]  idx;
        logic [7:0]  lost;
        logic [10:0] cfg;
    } vec_t;

    vec_t vecs[33];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic rst, input logic rdy,
                             input logic fail, input logic [1:0] idx,
                             input logic [7:0] lost, input logic [10:0] cfg);
        check({tag, "_pll_reset"}, 32'(pll_reset), 32'(rst));
        check({tag, "_pll_ready"}, 32'(pll_ready), 32'(rdy));
        check({tag, "_cfg_fail"},  32'(cfg_fail),  32'(fail));
        check({tag, "_cfg_idx"},   32'(cfg_idx),   32'(idx));
        check({tag, "_lost_cnt"},  32'(lost_cnt),  32'(lost));
        check({tag, "_cfg_word"},  32'({icpsel, lpfres, lpfcap}), 32'(cfg));
    endtask

    task automatic wait_ready(input logic val, input int budget, input string tag);
        int k;
        k = 0;
        while ((pll_ready !== val) && (k < budget)) begin
            step();
            k++;
        end
        check({tag, "_ready_within_budget"}, 32'(pll_ready), 32'(val));
    endtask

    initial begin
        logic [7:0] exp_lost;

        // Checkpoints: {steps, lock, req} -> {reset, ready, fail, idx, lost, cfg}
        vecs[0]  = '{3,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, E0};
        vecs[1]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, E0};
        vecs[2]  = '{10,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, E0};
        vecs[3]  = '{9,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, E0};
        vecs[4]  = '{1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, E0};
        vecs[5]  = '{2,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, E0};
        vecs[6]  = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[7]  = '{3,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[8]  = '{1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[9]  = '{7,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[10] = '{1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1, E0};
        vecs[11] = '{1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[12] = '{4,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[13] = '{5,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[14] = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[15] = '{9,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[16] = '{1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1, E0};
        vecs[17] = '{1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[18] = '{4,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[19] = '{99,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[20] = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1, E1};
        vecs[21] = '{103, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1, E1};
        vecs[22] = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd1, E2};
        vecs[23] = '{104, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 8'd1, E3};
        vecs[24] = '{104, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'd1, E3};
        vecs[25] = '{10,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'd1, E3};
        vecs[26] = '{1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[27] = '{3,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[28] = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[29] = '{99,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[30] = '{1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[31] = '{3,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1, E0};
        vecs[32] = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, E0};

        rst_n    = 1'b0;
        cfg_req  = 1'b0;
        pll_lock = 1'b0;
        repeat (3) step();
        check_all("reset", 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, E0);
        rst_n = 1'b1;

        for (int i = 0; i < 33; i++) begin
            pll_lock = vecs[i].lock;
            cfg_req  = vecs[i].req;
            step();
            cfg_req = 1'b0;
            for (int k = 1; k < vecs[i].n; k++) step();
            check_all($sformatf("vec%0d", i), vecs[i].rst, vecs[i].rdy, vecs[i].fail,
                      vecs[i].idx, vecs[i].lost, vecs[i].cfg);
        end

        // Repeated lock losses: lost_cnt climbs by one per loss and sticks at 255.
        exp_lost = 8'd1;
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b1;
            wait_ready(1'b1, 40, $sformatf("loss%0d_lock", i));
            pll_lock = 1'b0;
            wait_ready(1'b0, 10, $sformatf("loss%0d_drop", i));
            if (exp_lost != 8'hFF) exp_lost = exp_lost + 8'd1;
            check($sformatf("loss%0d_lost_cnt", i), 32'(lost_cnt), 32'(exp_lost));
            check($sformatf("loss%0d_cfg_idx", i), 32'(cfg_idx), 32'd0);
        end
        check("final_lost_saturated", 32'(lost_cnt), 32'd255);
        check("final_pll_reset", 32'(pll_reset), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
